alu_issue_ctrl: RTL and testbench

- Sequential decode/issue controller that drives the 32-bit datapath ALU (ALUop/in1/in2/imm/sh) and consumes its result.
- Accepts MIPS-format instruction words over a valid/ready handshake and decodes them to the ALU's 3-bit operation code.
- Reads operands from an internal 32x32 register file, holds them on the ALU ports for a programmable number of cycles, then writes the result back.
- Sits between the instruction source and the ALU.

---
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Decode/issue controller for the 32-bit datapath ALU.
// Accepts MIPS words, reads the register file, holds the ALU operands, then writes the result back.
module alu_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [15:0]       alu_imm,
    output logic [4:0]        alu_sh,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [31:0]       ir;
    logic [CW-1:0]     cnt;
    logic [4:0]        dst;
    logic [DATA_W-1:0] rf [32];

    logic [5:0] opc;
    logic [5:0] fn;
    logic       rtype;
    logic [2:0] dec_op;
    logic [4:0] dec_dst;
    logic       dec_ok;

    assign opc   = ir[31:26];
    assign fn    = ir[5:0];
    assign rtype = (opc == 6'h00);

    always_comb begin
        dec_op  = 3'b000;
        dec_dst = ir[15:11];
        dec_ok  = 1'b1;
        unique case (1'b1)
            rtype && fn == 6'h20: dec_op = 3'b000;
            rtype && fn == 6'h22: dec_op = 3'b001;
            rtype && fn == 6'h25: dec_op = 3'b011;
            rtype && fn == 6'h00: dec_op = 3'b101;
            rtype && fn == 6'h02: dec_op = 3'b110;
            rtype && fn == 6'h03: dec_op = 3'b111;
            opc == 6'h08: begin
                dec_op  = 3'b010;
                dec_dst = ir[20:16];
            end
            opc == 6'h0D: begin
                dec_op  = 3'b100;
                dec_dst = ir[20:16];
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (instr_valid) state_n = DECODE;
            DECODE:  state_n = dec_ok ? EXEC : IDLE;
            EXEC:    if (cnt == '0) state_n = WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE);
    assign wb_valid    = (state == WB);
    assign dbg_data    = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    // R0 is never written, so its entry stays at its reset value of 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            cnt     <= '0;
            dst     <= '0;
            alu_op  <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_imm <= '0;
            alu_sh  <= '0;
            wb_addr <= '0;
            wb_data <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            illegal <= 1'b0;
            unique case (state)
                IDLE: if (instr_valid) ir <= instr;
                DECODE: begin
                    if (dec_ok) begin
                        alu_op  <= dec_op;
                        alu_in1 <= rf[ir[25:21]];
                        alu_in2 <= rf[ir[20:16]];
                        alu_imm <= ir[15:0];
                        alu_sh  <= ir[10:6];
                        dst     <= dec_dst;
                        cnt     <= CW'(EXEC_CYCLES - 1);
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        wb_data <= alu_result;
                        wb_addr <= dst;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WB: if (wb_addr != 5'd0) rf[wb_addr] <= wb_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU.
// Covers a 1-cycle and a 3-cycle execute build.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    logic        iv;
    logic        ir_rdy;
    logic [31:0] iw;
    logic [2:0]  op;
    logic [31:0] in1, in2, res;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ill;
    logic [4:0]  da;
    logic [31:0] dd;

    logic        iv3;
    logic        ir_rdy3;
    logic [31:0] iw3;
    logic [2:0]  op3;
    logic [31:0] in13, in23, res3;
    logic [15:0] imm3;
    logic [4:0]  sh3;
    logic        wbv3;
    logic [4:0]  wba3;
    logic [31:0] wbd3;
    logic        ill3;
    logic [4:0]  da3;
    logic [31:0] dd3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(input logic [2:0] o,
        input logic [31:0] a, input logic [31:0] b,
        input logic [15:0] i, input logic [4:0] s);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a + {{16{i[15]}}, i};
            3'd3: return a | b;
            3'd4: return a | {16'h0, i};
            3'd5: return b << s;
            3'd6: return b >> s;
            default: return $signed(b) >>> s;
        endcase
    endfunction

    assign res  = alu_f(op, in1, in2, imm, sh);
    assign res3 = alu_f(op3, in13, in23, imm3, sh3);

    alu_issue_ctrl #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(iv), .instr_ready(ir_rdy), .instr(iw),
        .alu_op(op), .alu_in1(in1), .alu_in2(in2),
        .alu_imm(imm), .alu_sh(sh), .alu_result(res),
        .wb_valid(wbv), .wb_addr(wba), .wb_data(wbd),
        .illegal(ill), .dbg_addr(da), .dbg_data(dd)
    );

    alu_issue_ctrl #(.EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(iv3), .instr_ready(ir_rdy3), .instr(iw3),
        .alu_op(op3), .alu_in1(in13), .alu_in2(in23),
        .alu_imm(imm3), .alu_sh(sh3), .alu_result(res3),
        .wb_valid(wbv3), .wb_addr(wba3), .wb_data(wbd3),
        .illegal(ill3), .dbg_addr(da3), .dbg_data(dd3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // returns just after the accepting edge, in DECODE
    task automatic send(input logic [31:0] w);
        int k = 0;
        @(negedge clk);
        while (!ir_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ir_rdy) chk("send_rdy", 32'(ir_rdy), 32'd1);
        iw = w;
        iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] w,
                       input logic [4:0] a, input logic [31:0] d);
        send(w);
        step(3);
        chk({tag, "_wbv"}, 32'(wbv), 32'd1);
        chk({tag, "_wba"}, 32'(wba), 32'(a));
        chk({tag, "_wbd"}, wbd, d);
        step(1);
        da = a;
        #1 chk({tag, "_dbg"}, dd, (a == 5'd0) ? 32'd0 : d);
    endtask

    logic [31:0] words3 [3];
    int acc [3];
    int wbt [3];
    logic [31:0] wbdat [3];
    int n, m, nz, wbseen;

    initial begin
        iv = 1'b0; iw = '0; da = '0;
        iv3 = 1'b0; iw3 = '0; da3 = '0;
        step(2);
        chk("rst_ready", 32'(ir_rdy), 32'd1);
        chk("rst_wbv", 32'(wbv), 32'd0);
        chk("rst_ill", 32'(ill), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_wbd", wbd, 32'd0);
        rst_n = 1'b1;
        step(1);

        // ADDI r1,r0,0xFFFF with cycle-exact latency
        send(32'h2001FFFF);
        step(1);
        chk("addi_dec_wbv", 32'(wbv), 32'd0);
        chk("addi_dec_rdy", 32'(ir_rdy), 32'd0);
        step(1);
        chk("addi_op", 32'(op), 32'd2);
        chk("addi_imm", 32'(imm), 32'h0000FFFF);
        chk("addi_ex_wbv", 32'(wbv), 32'd0);
        step(1);
        chk("addi_wbv", 32'(wbv), 32'd1);
        chk("addi_wba", 32'(wba), 32'd1);
        chk("addi_wbd", wbd, 32'hFFFFFFFF);
        step(1);
        da = 5'd1;
        #1 chk("addi_dbg", dd, 32'hFFFFFFFF);
        chk("addi_post_wbv", 32'(wbv), 32'd0);
        chk("addi_post_rdy", 32'(ir_rdy), 32'd1);

        run("ori", 32'h34028000, 5'd2, 32'h00008000);

        // SRA r3,r2,4 right after its producer
        send(32'h00021903);
        step(2);
        chk("sra_op", 32'(op), 32'd7);
        chk("sra_in2", in2, 32'h00008000);
        chk("sra_sh", 32'(sh), 32'd4);
        step(1);
        chk("sra_wbd", wbd, 32'h00000800);
        chk("sra_wba", 32'(wba), 32'd3);

        send(32'h00222022);
        step(2);
        chk("sub_op", 32'(op), 32'd1);
        chk("sub_in1", in1, 32'hFFFFFFFF);
        step(1);
        chk("sub_wbd", wbd, 32'hFFFF7FFF);
        step(1);
        da = 5'd4;
        #1 chk("sub_dbg", dd, 32'hFFFF7FFF);

        // illegal opcode: pulse, no writeback, state untouched
        send(32'hFC000000);
        step(1);
        chk("ill_dec", 32'(ill), 32'd0);
        step(1);
        chk("ill_pulse", 32'(ill), 32'd1);
        chk("ill_rdy", 32'(ir_rdy), 32'd1);
        chk("ill_wbv", 32'(wbv), 32'd0);
        chk("ill_op_hold", 32'(op), 32'd1);
        chk("ill_in2_hold", in2, 32'h00008000);
        chk("ill_wba_hold", 32'(wba), 32'd4);
        step(1);
        chk("ill_one", 32'(ill), 32'd0);
        chk("ill_wbv2", 32'(wbv), 32'd0);
        #1 chk("ill_rf", dd, 32'hFFFF7FFF);

        send(32'h00000021);
        step(2);
        chk("ill_fn", 32'(ill), 32'd1);

        run("addi_r0", 32'h20000005, 5'd0, 32'd5);
        run("or", 32'h00223025, 5'd6, 32'hFFFFFFFF);
        run("sll", 32'h000238C0, 5'd7, 32'h00040000);
        run("srl", 32'h00044202, 5'd8, 32'h00FFFF7F);
        run("add", 32'h00424820, 5'd9, 32'h00010000);

        // 3-cycle build fed back-to-back with valid held high
        words3[0] = 32'h20010001;
        words3[1] = 32'h20220002;
        words3[2] = 32'h00221820;
        n = 0;
        m = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wbv3 && m < 3) begin
                wbt[m] = cyc;
                wbdat[m] = wbd3;
                m++;
            end
            iv3 = (n < 3);
            if (n < 3) begin
                iw3 = words3[n];
                if (ir_rdy3) begin
                    acc[n] = cyc;
                    n++;
                end
            end
        end
        iv3 = 1'b0;
        chk("e3_accepts", 32'(n), 32'd3);
        chk("e3_wbs", 32'(m), 32'd3);
        if (n == 3 && m == 3) begin
            chk("e3_gap01", 32'(acc[1] - acc[0]), 32'd6);
            chk("e3_gap12", 32'(acc[2] - acc[1]), 32'd6);
            chk("e3_lat", 32'(wbt[0] - acc[0]), 32'd5);
            chk("e3_d0", wbdat[0], 32'd1);
            chk("e3_d1", wbdat[1], 32'd3);
            chk("e3_d2", wbdat[2], 32'd4);
        end

        // reset during EXEC of ADD r5,r1,r1
        send(32'h00212820);
        step(2);
        chk("rst_pre_op", 32'(op), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(ir_rdy), 32'd1);
        chk("arst_wbv", 32'(wbv), 32'd0);
        nz = 0;
        for (int a = 0; a < 32; a++) begin
            da = 5'(a);
            #1 if (dd != 32'd0) nz++;
        end
        chk("arst_rf_zero", 32'(nz), 32'd0);
        step(2);
        rst_n = 1'b1;
        wbseen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wbv) wbseen++;
        end
        chk("arst_no_wb", 32'(wbseen), 32'd0);
        da = 5'd5;
        #1 chk("arst_r5", dd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
